// File: rtl/wbdma_sched_pkg.sv
// Shared constants for the DMA command scheduler: DMA/CPU register maps,
// DMA control keys and the scheduler state encoding.
package wbdma_sched_pkg;

  localparam logic [1:0] DMA_CTRL = 2'd0;
  localparam logic [1:0] DMA_LEN  = 2'd1;
  localparam logic [1:0] DMA_SRC  = 2'd2;
  localparam logic [1:0] DMA_DST  = 2'd3;

  localparam logic [15:0] START_KEY  = 16'h0fed;
  localparam logic [31:0] ABORT_WORD = 32'hffed0000;

  localparam logic [2:0] REG_LEN    = 3'd0;
  localparam logic [2:0] REG_SRC    = 3'd1;
  localparam logic [2:0] REG_DST    = 3'd2;
  localparam logic [2:0] REG_CMD    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_SRC, ST_DST, ST_START, ST_WAIT, ST_STAT, ST_ABORT
  } state_t;

endpackage

// File: rtl/wbdma_cmdfifo.sv
// Descriptor ring buffer; pushes on full and pops on empty are ignored,
// flush empties the ring and overrides any push/pop in the same cycle.
module wbdma_cmdfifo #(
  parameter int PW     = 112,
  parameter int LGFIFO = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [PW-1:0]     i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [PW-1:0]     o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LGFIFO:0]   o_count
);

  logic [PW-1:0]     mem_q [2**LGFIFO];
  logic [LGFIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic [LGFIFO:0]   count_q;
  logic              push_ok, pop_ok;

  assign o_full   = (count_q == (LGFIFO+1)'(2**LGFIFO));
  assign o_empty  = (count_q == '0);
  assign o_count  = count_q;
  assign o_data   = mem_q[rd_ptr_q];
  assign push_ok  = i_push && !o_full && !i_flush;
  assign pop_ok   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + LGFIFO'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + LGFIFO'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (LGFIFO+1)'(1);
        2'b01:   count_q <= count_q - (LGFIFO+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wbdma_sched.sv
// Command-queue scheduler in front of the wishbone DMA control port: programs,
// starts and checks each queued descriptor, interrupting once per drain/error.
//
// state    | meaning
// ST_IDLE  | waiting for a descriptor (LEN==0 entries retire here)
// ST_LEN   | writing transfer length
// ST_SRC   | writing source address
// ST_DST   | writing destination address
// ST_START | writing start key + control bits
// ST_WAIT  | waiting for DMA interrupt
// ST_STAT  | reading DMA status, retiring the descriptor
// ST_ABORT | writing abort word, flushing the queue
module wbdma_sched
  import wbdma_sched_pkg::*;
#(
  parameter int AW     = 32,
  parameter int LGFIFO = 2,
  parameter int DW     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [2:0]    i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [DW-1:0] o_wb_data,
  output logic          o_dma_cyc,
  output logic          o_dma_stb,
  output logic          o_dma_we,
  output logic [1:0]    o_dma_addr,
  output logic [DW-1:0] o_dma_data,
  input  logic          i_dma_ack,
  input  logic          i_dma_stall,
  input  logic [DW-1:0] i_dma_data,
  input  logic          i_dma_int,
  output logic          o_interrupt
);

  localparam int PW = 3*AW + 16;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d, irq_q, irq_d;
  logic [1:0]      addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      stat_q, stat_d;
  logic [AW-1:0]   len_q, src_q, dst_q;
  logic            err_q, ovf_q, aborting_q, ack_q;
  logic [31:0]     done_q, status_w;
  logic [DW-1:0]   rdata, rdata_q, acc_data;
  logic [1:0]      acc_addr;
  logic            acc_we, pop, flush, done_inc, err_set, abort_clr;
  logic            wb_req, wb_wr, push, busy, drained, dma_ack;
  logic [PW-1:0]   fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [LGFIFO:0] fifo_count;
  logic [AW-1:0]   head_len, head_src, head_dst;
  logic [15:0]     head_ctrl;
  logic            unused_dma_bits;

  assign wb_req   = i_wb_cyc && i_wb_stb;
  assign wb_wr    = wb_req && i_wb_we;
  assign push     = wb_wr && (i_wb_addr == REG_CMD);
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign drained  = (fifo_count == (LGFIFO+1)'(1)) && !push;
  assign dma_ack  = cyc_q && i_dma_ack;
  assign head_len  = fifo_dout[PW-1 -: AW];
  assign head_src  = fifo_dout[2*AW+15 -: AW];
  assign head_dst  = fifo_dout[AW+15 -: AW];
  assign head_ctrl = fifo_dout[15:0];
  assign status_w = {busy, err_q, ovf_q, aborting_q, 12'b0, 8'(fifo_count), stat_q};
  assign unused_dma_bits = ^i_dma_data[DW-9:0];

  wbdma_cmdfifo #(.PW(PW), .LGFIFO(LGFIFO)) u_cmdfifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  ({len_q, src_q, dst_q, i_wb_data[15:0]}),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    acc_we   = 1'b1;
    acc_addr = DMA_CTRL;
    acc_data = '0;
    case (state_q)
      ST_LEN:   begin acc_addr = DMA_LEN; acc_data = DW'(head_len); end
      ST_SRC:   begin acc_addr = DMA_SRC; acc_data = DW'(head_src); end
      ST_DST:   begin acc_addr = DMA_DST; acc_data = DW'(head_dst); end
      ST_START: acc_data = DW'({START_KEY, head_ctrl});
      ST_STAT:  acc_we = 1'b0;
      ST_ABORT: acc_data = DW'(ABORT_WORD);
      default:  acc_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    stat_d    = stat_q;
    irq_d     = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    done_inc  = 1'b0;
    err_set   = 1'b0;
    abort_clr = 1'b0;
    if (cyc_q && stb_q && !i_dma_stall) stb_d = 1'b0;
    if (dma_ack) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (aborting_q) state_d = ST_ABORT;
        else if (!fifo_empty && !err_q) begin
          if (head_len == '0) begin
            pop      = 1'b1;
            done_inc = 1'b1;
            irq_d    = drained;
          end else state_d = ST_LEN;
        end
      end
      ST_WAIT: begin
        if (aborting_q)     state_d = ST_ABORT;
        else if (i_dma_int) state_d = ST_STAT;
      end
      default: begin
        // Bus accesses launch only from an idle bus, so an abort raised mid-access waits for its ack.
        if (!cyc_q) begin
          if (aborting_q && state_q != ST_ABORT) state_d = ST_ABORT;
          else begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = acc_we;
            addr_d = acc_addr;
            data_d = acc_data;
          end
        end else if (dma_ack) begin
          if (state_q == ST_STAT) stat_d = i_dma_data[DW-1 -: 8];
          if (state_q == ST_ABORT) begin
            flush     = 1'b1;
            abort_clr = 1'b1;
            state_d   = ST_IDLE;
          end else if (aborting_q) state_d = ST_ABORT;
          else begin
            case (state_q)
              ST_LEN:   state_d = ST_SRC;
              ST_SRC:   state_d = ST_DST;
              ST_DST:   state_d = ST_START;
              ST_START: state_d = ST_WAIT;
              ST_STAT: begin
                if (!i_dma_data[DW-1]) begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
                  if (i_dma_data[DW-2]) begin
                    err_set = 1'b1;
                    irq_d   = 1'b1;
                  end else begin
                    done_inc = 1'b1;
                    irq_d    = drained;
                  end
                end
              end
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stat_q  <= stat_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (i_wb_addr)
      REG_LEN:    rdata = DW'(len_q);
      REG_SRC:    rdata = DW'(src_q);
      REG_DST:    rdata = DW'(dst_q);
      REG_STATUS: rdata = DW'(status_w);
      REG_DONE:   rdata = DW'(done_q);
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      aborting_q <= 1'b0;
      done_q     <= '0;
    end else begin
      ack_q   <= wb_req;
      rdata_q <= rdata;
      if (wb_wr && i_wb_addr == REG_LEN) len_q <= i_wb_data[AW-1:0];
      if (wb_wr && i_wb_addr == REG_SRC) src_q <= i_wb_data[AW-1:0];
      if (wb_wr && i_wb_addr == REG_DST) dst_q <= i_wb_data[AW-1:0];
      // New events win over a simultaneous CPU clear.
      if (wb_wr && i_wb_addr == REG_STATUS && i_wb_data[0]) begin
        err_q <= 1'b0;
        ovf_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (push && fifo_full) ovf_q <= 1'b1;
      if (abort_clr) aborting_q <= 1'b0;
      if (wb_wr && i_wb_addr == REG_STATUS && i_wb_data[1]) aborting_q <= 1'b1;
      if (wb_wr && i_wb_addr == REG_DONE) done_q <= '0;
      else if (done_inc) done_q <= done_q + 32'd1;
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_stall  = 1'b0;
  assign o_wb_data   = rdata_q;
  assign o_dma_cyc   = cyc_q;
  assign o_dma_stb   = stb_q;
  assign o_dma_we    = we_q;
  assign o_dma_addr  = addr_q;
  assign o_dma_data  = data_q;
  assign o_interrupt = irq_q;

endmodule

// File: tb/tb_wbdma_sched.sv
// Directed bench for wbdma_sched: register-map vector table plus sequences for
// dispatch, queue overflow, DMA error, abort, zero-length and reset corners.
module tb_wbdma_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [2:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_dma_cyc, o_dma_stb, o_dma_we;
  logic [1:0]  o_dma_addr;
  logic [31:0] o_dma_data;
  logic        i_dma_ack, i_dma_stall, i_dma_int;
  logic [31:0] i_dma_data;
  logic        o_interrupt;

  always #5 i_clk = ~i_clk;

  wbdma_sched #(.AW(32), .LGFIFO(2), .DW(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_dma_cyc(o_dma_cyc), .o_dma_stb(o_dma_stb), .o_dma_we(o_dma_we),
    .o_dma_addr(o_dma_addr), .o_dma_data(o_dma_data),
    .i_dma_ack(i_dma_ack), .i_dma_stall(i_dma_stall), .i_dma_data(i_dma_data),
    .i_dma_int(i_dma_int), .o_interrupt(o_interrupt)
  );

  // DMA control-port model
  logic        ack_q, int_q, stall_tgl, man_int = 1'b0;
  logic [31:0] rdata_q;
  bit          stall_mode = 0, stall_all = 0, auto_int = 1;
  int          int_delay = 5, int_cnt = 0, busy_upto = 0;
  logic [31:0] status_val = '0;
  logic [33:0] wlog[$];
  int          rd_cnt = 0, acc_cnt = 0, irq_cnt = 0;
  int          total = 0, bad = 0;

  assign i_dma_ack   = ack_q;
  assign i_dma_data  = rdata_q;
  assign i_dma_stall = stall_all | (stall_mode & stall_tgl);
  assign i_dma_int   = int_q | man_int;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q <= 1'b0; int_q <= 1'b0; int_cnt <= 0; stall_tgl <= 1'b0; rdata_q <= '0;
    end else begin
      stall_tgl <= ~stall_tgl;
      ack_q <= 1'b0;
      int_q <= 1'b0;
      if (int_cnt != 0) begin
        int_cnt <= int_cnt - 1;
        if (int_cnt == 1) int_q <= 1'b1;
      end
      if (o_dma_cyc && o_dma_stb && !i_dma_stall) begin
        ack_q <= 1'b1;
        acc_cnt++;
        if (o_dma_we) begin
          wlog.push_back({o_dma_addr, o_dma_data});
          if (auto_int && o_dma_addr == 2'd0 && o_dma_data[31:16] == 16'h0fed) int_cnt <= int_delay;
        end else begin
          rdata_q <= (rd_cnt < busy_upto) ? 32'h8000_0000 : status_val;
          rd_cnt++;
        end
      end
    end
  end

  always @(posedge i_clk) if (o_interrupt) irq_cnt++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic ack);
    @(negedge i_clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
    @(negedge i_clk);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    rd = o_wb_data; ack = o_wb_ack;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ack;
    wb_xfer(1'b1, a, d, rd, ack);
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd; logic ack;
    wb_xfer(1'b0, a, 32'h0, rd, ack);
    check(nm, rd, exp);
  endtask

  task automatic push_desc(input logic [31:0] l, s, d, input logic [15:0] c);
    wb_write(3'd0, l); wb_write(3'd1, s); wb_write(3'd2, d); wb_write(3'd3, {16'h0, c});
  endtask

  task automatic expect_desc(input int b, input logic [31:0] l, s, d, input logic [15:0] c, input string nm);
    logic [33:0] e [4];
    e[0] = {2'd1, l}; e[1] = {2'd2, s}; e[2] = {2'd3, d}; e[3] = {2'd0, 16'h0fed, c};
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_wr%0d", nm, i), (b + i < wlog.size()) ? wlog[b + i] : 34'h0, e[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_irq(input int tgt, input string nm);
    int k = 0;
    while (irq_cnt < tgt && k < 3000) begin @(negedge i_clk); k++; end
    check(nm, (irq_cnt >= tgt) ? 1 : 0, 1);
  endtask

  task automatic wait_log(input int tgt, input string nm);
    int k = 0;
    while (wlog.size() < tgt && k < 500) begin @(negedge i_clk); k++; end
    check(nm, (wlog.size() >= tgt) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int   wb, r0, i0, a0, k;
    logic [31:0] rd;
    logic ack;

    vecs[0]  = '{1'b1, 3'd0, 32'hdeadbeef, 32'h1, "wr_len_ack"};
    vecs[1]  = '{1'b0, 3'd0, 32'h0, 32'hdeadbeef, "rd_len_full"};
    vecs[2]  = '{1'b1, 3'd0, 32'h10, 32'h1, "wr_len2_ack"};
    vecs[3]  = '{1'b1, 3'd1, 32'h1000, 32'h1, "wr_src_ack"};
    vecs[4]  = '{1'b1, 3'd2, 32'h2000, 32'h1, "wr_dst_ack"};
    vecs[5]  = '{1'b0, 3'd0, 32'h0, 32'h10, "rd_len"};
    vecs[6]  = '{1'b0, 3'd1, 32'h0, 32'h1000, "rd_src"};
    vecs[7]  = '{1'b0, 3'd2, 32'h0, 32'h2000, "rd_dst"};
    vecs[8]  = '{1'b0, 3'd4, 32'h0, 32'h0, "rd_status_idle"};
    vecs[9]  = '{1'b0, 3'd5, 32'h0, 32'h0, "rd_done_reset"};
    vecs[10] = '{1'b0, 3'd6, 32'h0, 32'h0, "rd_addr6"};
    vecs[11] = '{1'b0, 3'd7, 32'h0, 32'h0, "rd_addr7"};

    repeat (3) @(negedge i_clk);
    check("rst_dma_cyc", o_dma_cyc, 0);
    check("rst_dma_stb", o_dma_stb, 0);
    check("rst_irq", o_interrupt, 0);
    check("rst_wb_ack", o_wb_ack, 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].data, rd, ack);
      check(vecs[i].nm, vecs[i].we ? {31'h0, ack} : rd, vecs[i].exp);
    end

    // single descriptor, first status read reports DMA still busy
    wb = wlog.size(); r0 = rd_cnt; i0 = irq_cnt;
    busy_upto = rd_cnt + 1; status_val = 32'h0; int_delay = 5;
    wb_write(3'd3, 32'h0);
    wait_irq(i0 + 1, "t1_irq_seen");
    wait_cycles(30);
    check("t1_wr_count", wlog.size() - wb, 4);
    expect_desc(wb, 32'h10, 32'h1000, 32'h2000, 16'h0000, "t1");
    check("t1_stat_reads", rd_cnt - r0, 2);
    rd_check(3'd5, 32'd1, "t1_done");
    check("t1_irq_count", irq_cnt - i0, 1);
    rd_check(3'd4, 32'h0, "t1_status");

    // three back-to-back descriptors with a stalling DMA
    stall_mode = 1; int_delay = 40;
    wb_write(3'd5, 32'h0);
    wb = wlog.size(); i0 = irq_cnt;
    push_desc(32'h20, 32'h3000, 32'h4000, 16'h0001);
    push_desc(32'h44, 32'h5000, 32'h6000, 16'h0002);
    push_desc(32'h08, 32'h7100, 32'h7200, 16'h00ff);
    wait_irq(i0 + 1, "t2_irq_seen");
    wait_cycles(60);
    check("t2_wr_count", wlog.size() - wb, 12);
    expect_desc(wb,     32'h20, 32'h3000, 32'h4000, 16'h0001, "t2a");
    expect_desc(wb + 4, 32'h44, 32'h5000, 32'h6000, 16'h0002, "t2b");
    expect_desc(wb + 8, 32'h08, 32'h7100, 32'h7200, 16'h00ff, "t2c");
    rd_check(3'd5, 32'd3, "t2_done");
    check("t2_irq_count", irq_cnt - i0, 1);
    rd_check(3'd4, 32'h0, "t2_status");
    stall_mode = 0;

    // DMA error halts dispatch, queue overflows, clearing err resumes
    status_val = 32'h4000_0000; int_delay = 40;
    wb_write(3'd5, 32'h0);
    wb = wlog.size(); i0 = irq_cnt;
    push_desc(32'h4, 32'h100, 32'h200, 16'h0003);
    push_desc(32'h5, 32'h110, 32'h210, 16'h0004);
    wait_irq(i0 + 1, "t3_err_irq_seen");
    wait_cycles(10);
    rd_check(3'd4, 32'hC000_0140, "t3_status_err");
    check("t3_wr_count_err", wlog.size() - wb, 4);
    expect_desc(wb, 32'h4, 32'h100, 32'h200, 16'h0003, "t3e");
    rd_check(3'd5, 32'd0, "t3_done_err");
    push_desc(32'h6, 32'h120, 32'h220, 16'h0005);
    push_desc(32'h7, 32'h130, 32'h230, 16'h0006);
    push_desc(32'h8, 32'h140, 32'h240, 16'h0007);
    push_desc(32'h9, 32'h150, 32'h250, 16'h0008);
    rd_check(3'd4, 32'hE000_0440, "t3_status_ovf");
    check("t3_no_dispatch", wlog.size() - wb, 4);
    status_val = 32'h0; int_delay = 5;
    wb = wlog.size();
    wb_write(3'd4, 32'h1);
    wait_irq(i0 + 2, "t3_resume_irq_seen");
    wait_cycles(30);
    check("t3_wr_count_resume", wlog.size() - wb, 16);
    expect_desc(wb,      32'h5, 32'h110, 32'h210, 16'h0004, "t3r0");
    expect_desc(wb + 12, 32'h8, 32'h140, 32'h240, 16'h0007, "t3r3");
    rd_check(3'd5, 32'd4, "t3_done_resume");
    check("t3_irq_count", irq_cnt - i0, 2);
    rd_check(3'd4, 32'h0, "t3_status_resume");

    // abort while waiting for the DMA interrupt
    auto_int = 0;
    wb_write(3'd5, 32'h0);
    wb = wlog.size(); i0 = irq_cnt;
    push_desc(32'h30, 32'h400, 32'h500, 16'h0009);
    push_desc(32'h31, 32'h410, 32'h510, 16'h000a);
    wait_log(wb + 4, "t4_programmed");
    wait_cycles(5);
    wb_write(3'd4, 32'h2);
    wait_log(wb + 5, "t4_abort_written");
    wait_cycles(10);
    check("t4_abort_word", (wb + 4 < wlog.size()) ? wlog[wb + 4] : 34'h0, {2'd0, 32'hffed0000});
    rd_check(3'd4, 32'h0, "t4_status");
    check("t4_no_irq", irq_cnt - i0, 0);
    r0 = rd_cnt;
    @(negedge i_clk); man_int = 1'b1;
    @(negedge i_clk); man_int = 1'b0;
    wait_cycles(20);
    check("t4_late_int_wr", wlog.size() - wb, 5);
    check("t4_late_int_rd", rd_cnt - r0, 0);
    check("t4_late_int_irq", irq_cnt - i0, 0);
    rd_check(3'd5, 32'd0, "t4_done");

    // zero-length descriptor retires without DMA traffic
    auto_int = 1;
    a0 = acc_cnt;
    wb_write(3'd0, 32'h0);
    wb_write(3'd3, 32'h5);
    wait_cycles(20);
    check("t5_no_bus", acc_cnt - a0, 0);
    rd_check(3'd5, 32'd1, "t5_done");
    rd_check(3'd4, 32'h0, "t5_status");

    // reset asserted while the start write is on the bus
    auto_int = 0;
    wb = wlog.size();
    push_desc(32'h10, 32'h8000, 32'h9000, 16'h0007);
    wait_log(wb + 3, "t6_dst_written");
    stall_all = 1;
    k = 0;
    while (!(o_dma_cyc && o_dma_we && o_dma_addr == 2'd0) && k < 50) begin @(negedge i_clk); k++; end
    check("t6_start_on_bus", (o_dma_cyc && o_dma_addr == 2'd0) ? 1 : 0, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", o_dma_cyc, 0);
    check("t6_rst_stb", o_dma_stb, 0);
    wait_cycles(2);
    stall_all = 0;
    i_rst_n = 1'b1;
    rd_check(3'd4, 32'h0, "t6_status_after_rst");
    rd_check(3'd5, 32'h0, "t6_done_after_rst");
    rd_check(3'd0, 32'h0, "t6_len_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbdma_sched.md
Name: wbdma_sched

Overview:
- Command-queue scheduler that sits in front of the wishbone DMA controller's 4-register control slave port.
- The CPU stages transfer descriptors (length, source, destination, control) into a small FIFO.
- The scheduler programs the DMA with each descriptor in turn, starts it, waits for its completion interrupt, checks status, then dispatches the next one.
- The CPU only services one interrupt per drained queue or error, not one per transfer.

Parameters:
AW, 32, DMA address/length width (LEN/SRC/DST zero-extended to 32 on the bus)
LGFIFO, 2, log2 of descriptor FIFO depth (4 entries)
DW, 32, data width of both wishbone ports

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous, active-low reset
i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  CPU-side slave wishbone
i_wb_addr  in  3  CPU register select
i_wb_data  in  DW  CPU write data
o_wb_ack  out  1  ack, one cycle after stb
o_wb_stall  out  1  tied 0
o_wb_data  out  DW  CPU read data
o_dma_cyc, o_dma_stb, o_dma_we  out  1 each  master to DMA control port
o_dma_addr  out  2  DMA register: 0 ctrl, 1 len, 2 src, 3 dst
o_dma_data  out  DW  DMA write data
i_dma_ack, i_dma_stall  in  1 each  DMA slave responses
i_dma_data  in  DW  DMA read data
i_dma_int  in  1  DMA completion/error interrupt (1-cycle pulse)
o_interrupt  out  1  registered 1-cycle pulse

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, all sticky flags 0, done count 0.
- CPU map:
  - 0 LEN, 1 SRC, 2 DST: R/W staging registers.
  - 3 CMD: a write pushes {LEN,SRC,DST,data[15:0]}. If the FIFO is full, the push is dropped and sticky ovf is set.
  - 4 STATUS read: {busy[31], err[30], ovf[29], aborting[28], 12'b0, count[15:8] zero-ext, last DMA status bits 31..24 captured[7:0]}.
  - STATUS write: bit0 clears err and ovf; bit1 requests abort.
  - 5 DONE: 32-bit count of completed descriptors, wraps; write clears it.
  - 6–7 read 0.
- o_wb_ack: 1 cycle after i_wb_stb, regardless of busy. o_wb_data is registered from i_wb_addr.
- Master bus transaction rule: one access at a time.
  - Assert cyc+stb; drop stb on the first cycle with !i_dma_stall.
  - Hold cyc until i_dma_ack.
  - Next access no earlier than the cycle after the ack.
- FSM:
  - IDLE: if FIFO non-empty, !err and !abort, move to LEN. If head LEN==0, pop it, increment DONE, stay IDLE with no DMA access.
  - LEN: write addr1 = head LEN → SRC.
  - SRC: write addr2 = head SRC → DST.
  - DST: write addr3 = head DST → START.
  - START: write addr0 = {16'h0fed, head ctrl[15:0]} → WAIT.
  - WAIT: on i_dma_int → STAT.
  - STAT: read addr0 and capture data[31:24].
    - If bit31 (DMA busy) is set, re-read next cycle.
    - Else pop the FIFO.
    - If bit30 is set, set err and pulse o_interrupt.
    - Else increment DONE, and pulse o_interrupt if the FIFO is now empty.
    - → IDLE.
  - ABORT: write addr0 = 32'hffed0000, flush FIFO, clear aborting → IDLE. Any i_dma_int seen in ABORT is ignored.
- Abort request:
  - Sets aborting.
  - From IDLE or WAIT: enter ABORT next cycle.
  - From LEN..STAT: finish the in-flight bus access, then enter ABORT.
  - Abort does not set err and does not interrupt.
- busy = state != IDLE or FIFO non-empty.
- Push and pop in the same cycle are legal; count is unchanged. A push on full is dropped even if a pop occurs that cycle.
- err set halts dispatch; the FIFO is retained. Clearing err resumes dispatch.
- Ring pointers are LGFIFO bits; count is LGFIFO+1 bits.
- Reset asserted mid-transfer drops cyc/stb immediately; the DMA is not aborted by this block.

Decomposition:
- Shared package holds:
  - DMA register offsets, start key 16'h0fed, abort word 32'hffed0000.
  - CPU register offsets and the FSM state encoding.
- One sub-module, wbdma_cmdfifo: a synchronous FIFO with async active-low reset, full/empty/count outputs, and payload width 3*AW+16.

Test Plan:
- Push LEN=16, SRC=0x1000, DST=0x2000, CMD=0x0000; DMA model pulses i_dma_int; status read returns 0 → DMA writes in order (1,16), (2,0x1000), (3,0x2000), (0,0x0fed0000); DONE=1; one o_interrupt pulse.
- Push 3 descriptors back-to-back → three full programming sequences, no CPU traffic needed; DONE=3; exactly one o_interrupt after the third.
- Push 5 with LGFIFO=2 and dispatch blocked → 5th dropped, ovf=1, count=4.
- Model returns status 0x40000000 → err=1, o_interrupt pulse, remaining entries kept. Write STATUS=1 → dispatch resumes.
- Abort during WAIT with 2 queued → write (0, 0xffed0000), FIFO count 0, no interrupt, late i_dma_int ignored.
- Descriptor with LEN=0 → no DMA bus cycles, DONE increments. Also assert i_rst_n=0 mid-START → o_dma_cyc=0 within the same cycle.
